// File: rtl/lvg_systolic_mm.sv
// rtl/lvg_systolic_mm.sv - N x N output-stationary systolic integer matrix multiplier
module lvg_systolic_mm #(
  parameter int N      = 4,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int CNT_W  = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      instr_valid,
  input  logic [7:0]                instr,
  input  logic [N*N*DATA_W-1:0]     l_flat,
  input  logic [N*N*DATA_W-1:0]     r_flat,
  output logic                      busy,
  output logic                      done,
  output logic [CNT_W-1:0]          sys_count,
  output logic [N*N*ACC_W-1:0]      c_flat
);

  localparam int PW = 2 * DATA_W;
  localparam logic [CNT_W-1:0] DRAIN_STEP = CNT_W'(3 * N - 2);

  localparam logic [7:0] OP_LOAD_L     = 8'd1;
  localparam logic [7:0] OP_LOAD_R     = 8'd2;
  localparam logic [7:0] OP_MATMUL     = 8'd3;
  localparam logic [7:0] OP_MATMUL_ACC = 8'd4;
  localparam logic [7:0] OP_CLEAR      = 8'd5;

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_FINISH} state_e;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     accept;
  logic                     start_mm;

  logic signed [DATA_W-1:0] l_q [N][N];
  logic signed [DATA_W-1:0] r_q [N][N];
  logic signed [DATA_W-1:0] a_q [N][N];
  logic signed [DATA_W-1:0] b_q [N][N];
  logic signed [ACC_W-1:0]  acc_q [N][N];
  logic signed [ACC_W-1:0]  acc_sum [N][N];
  logic signed [PW-1:0]     prod [N][N];
  logic signed [DATA_W-1:0] feed_l [N];
  logic signed [DATA_W-1:0] feed_r [N];
  logic [N*N*ACC_W-1:0]     c_q;

  assign accept   = instr_valid && (state_q == S_IDLE);
  assign start_mm = accept && ((instr == OP_MATMUL) || (instr == OP_MATMUL_ACC));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // COMPUTE runs one extra drain step so the last registered operand pair reaches PE(N-1,N-1).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_mm) begin
          state_d = S_COMPUTE;
          cnt_d   = '0;
        end
      end
      S_COMPUTE: begin
        if (cnt_q == DRAIN_STEP) begin
          state_d = S_FINISH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    busy      = (state_q == S_COMPUTE) && (cnt_q != DRAIN_STEP);
    done      = (state_q == S_FINISH);
    sys_count = cnt_q;
  end

  assign c_flat = c_q;

  // Edge injection: row i sees L[i][t-i], column j sees R[t-j][j], zero outside the window.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      feed_l[i] = '0;
      feed_r[i] = '0;
      for (int k = 0; k < N; k++) begin
        if (cnt_q == CNT_W'(i + k)) begin
          feed_l[i] = l_q[i][k];
          feed_r[i] = r_q[k][i];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        prod[i][j]    = PW'(a_q[i][j]) * PW'(b_q[i][j]);
        acc_sum[i][j] = acc_q[i][j] + ACC_W'(prod[i][j]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q <= '0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          l_q[i][j]   <= '0;
          r_q[i][j]   <= '0;
          a_q[i][j]   <= '0;
          b_q[i][j]   <= '0;
          acc_q[i][j] <= '0;
        end
      end
    end else if (state_q == S_COMPUTE) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_q[i][j]   <= (j == 0) ? feed_l[i] : a_q[i][(j == 0) ? 0 : j - 1];
          b_q[i][j]   <= (i == 0) ? feed_r[j] : b_q[(i == 0) ? 0 : i - 1][j];
          acc_q[i][j] <= acc_sum[i][j];
          if (cnt_q == DRAIN_STEP) begin
            c_q[(i*N+j)*ACC_W +: ACC_W] <= acc_sum[i][j];
          end
        end
      end
    end else if (accept) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if (instr == OP_LOAD_L) l_q[i][j] <= l_flat[(i*N+j)*DATA_W +: DATA_W];
          if (instr == OP_LOAD_R) r_q[i][j] <= r_flat[(i*N+j)*DATA_W +: DATA_W];
          if (start_mm) begin
            a_q[i][j] <= '0;
            b_q[i][j] <= '0;
          end
          if ((instr == OP_MATMUL) || (instr == OP_CLEAR)) acc_q[i][j] <= '0;
        end
      end
      if (instr == OP_CLEAR) c_q <= '0;
    end
  end

endmodule

// File: doc/lvg_systolic_mm.md
Name: lvg_systolic_mm

Overview:
- Parametrised successor of the fixed 4x4 lvg matrix unit.
- Owns an N x N output-stationary systolic array of signed integer MAC PEs, the left and right operand registers, skewed operand feeding, and a step counter.
- Adds: configurable size and widths, a valid/busy/done handshake, accumulate mode and an explicit clear.
- Sits between the instruction decoder and the vector register file, as a drop-in for lvg in integer builds.

Parameters:
- N, 4, matrix dimension (2..8).
- DATA_W, 16, signed operand width.
- ACC_W, 40, signed accumulator/result width; must satisfy ACC_W >= 2*DATA_W + clog2(N).
- CNT_W, 5, step counter width; must satisfy 2^CNT_W > 3N-2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr_valid  in  1  instr is presented this cycle.
- instr  in  8  opcode: 0 NOP, 1 LOAD_L, 2 LOAD_R, 3 MATMUL, 4 MATMUL_ACC, 5 CLEAR; others reserved.
- l_flat  in  N*N*DATA_W  left matrix, element (i,k) at bits [(i*N+k)*DATA_W +: DATA_W].
- r_flat  in  N*N*DATA_W  right matrix, element (k,j) at the same packing.
- busy  out  1  compute in progress.
- done  out  1  single-cycle pulse: result just became valid.
- sys_count  out  CNT_W  current compute step.
- c_flat  out  N*N*ACC_W  result matrix, element (i,j) at [(i*N+j)*ACC_W +: ACC_W].

Behaviour:
- Reset (asynchronous, any state): state IDLE; busy=0, done=0, sys_count=0, c_flat=0; L and R operand regs cleared to 0.
- States:
  - IDLE: accepts instructions.
  - COMPUTE: runs the array.
  - FINISH: one cycle, done=1.
- Acceptance: an instruction is accepted on a rising edge only if instr_valid=1 and state=IDLE. While busy or in FINISH, all instructions (including loads and CLEAR) are ignored. Reserved opcodes are ignored.
- LOAD_L / LOAD_R: latch l_flat / r_flat into the operand regs at the accepting edge. State stays IDLE; c_flat is unchanged.
- CLEAR: all accumulators and c_flat go to 0 at the accepting edge. Operand regs are unchanged.
- MATMUL: at the accepting edge, accumulators are zeroed, state goes to COMPUTE, busy=1, sys_count=0.
- MATMUL_ACC: identical to MATMUL, except the accumulators keep their current value.
- COMPUTE, step t = 0 .. 3N-3, one step per cycle, sys_count=t:
  - PE(i,j) adds sext(L[i][k]*R[k][j]) when k = t-i-j and 0 <= k < N.
  - The skew is implemented by horizontal/vertical pipeline registers between PEs: L flows right, R flows down, zeros are injected outside the valid window.
  - Products are signed DATA_W x DATA_W, full width, sign-extended to ACC_W. The sum wraps modulo 2^ACC_W.
- After step 3N-3: state becomes FINISH, busy=0, done=1 for exactly one cycle, and c_flat is updated with all accumulators simultaneously. Next cycle: IDLE, done=0, sys_count=0.
- Latency: done is high in the cycle starting 3N-1 rising edges after the accepting edge (N=4: 11).
- c_flat holds its value until the next FINISH, CLEAR or reset. Intermediate accumulator values are never visible on c_flat.
- Operand regs are not modified during COMPUTE; l_flat/r_flat changes then have no effect.
- Reset asserted mid-COMPUTE aborts immediately. No done pulse is produced, and the next accepted MATMUL_ACC starts from 0.

Test Plan (N=4, DATA_W=16, ACC_W=40):
- LOAD_R with R[0][0]=3, R[1][0]=5, rest 0; LOAD_L with L[0][0]=L[0][1]=1, rest 0; MATMUL -> done exactly 11 cycles after accept; c(0,0)=8, all other elements 0; busy high for 10 cycles, sys_count runs 0..9.
- L = identity, R[k][j] = 16k+j; MATMUL -> c(i,j) = 16i+j for all i,j.
- Same operands as the identity case; MATMUL then MATMUL_ACC -> c(i,j) = 2*(16i+j). Then CLEAR -> c_flat = 0, and a following MATMUL_ACC gives 16i+j.
- Signed extremes: L all -32768, R all -32768 -> every c = 4*2^30 = 0x0100000000. L all -1, R all 32767 -> every c = -131068.
- During COMPUTE drive instr_valid=1 with LOAD_L(all 7), CLEAR and MATMUL -> all ignored; result equals the pre-load expectation; exactly one done pulse.
- Assert rst while sys_count=5 -> busy, done, sys_count and c_flat read 0 immediately, with no clock edge needed. After release, LOAD both matrices then MATMUL_ACC -> result equals a plain MATMUL.
